bus_grant_arbiter_3: RTL
========================

// Module: bus_grant_arbiter_3
// PURPOSE
// - Three-requester bus arbiter for the ND-120 CPU board: synchronises raw request lines and issues one-hot grants.
// - Sequences turnaround and revokes stuck owners by timeout.
// - grant_o[2:0] feeds the downstream 3-input NOR stage that forms the active-high BUS_FREE signal.
// - Requesters: 0 = CPU, 1 = DMA, 2 = refresh.
// PARAMETERS
// - SYNC_STAGES     2    flip-flop stages per req_i bit; legal range 2..3.
// - TIMEOUT_CYCLES  255  maximum grant length in cycles before forced revoke; legal range 1..2^TMO_W-1.
// - TMO_W           8    width of the grant-length counter.
// PORTS
// - sysclk       in   1  single system clock; all state changes on the rising edge.
// - sysrst_n     in   1  reset, asynchronous assert, active-low.
// - req_i        in   3  raw, asynchronous, active-high requests. A requester holds its bit high while it owns the bus.
// - grant_o      out  3  registered one-hot grant, or all zero.
// - busy_o       out  1  high when state is not IDLE.
// - timeout_o    out  1  one-cycle pulse on a forced revoke.
// - owner_o      out  2  index of the current owner; 2'b11 when there is no owner.
// BEHAVIOUR
// - Reset (async, sysrst_n=0):
//   - All sync flops 0; state=IDLE; grant_o=0; busy_o=0; timeout_o=0; owner_o=2'b11; tmo_cnt=0; mask=0; rr_last=2.
//   - Reset mid-grant drops grant_o immediately (asynchronously).
// - Synchronisation: req_s = req_i delayed by SYNC_STAGES flops.
//   - No combinational path from req_i to any output.
// - Eligibility: elig = req_s & ~mask.
//   - mask[i] is set on a timeout of requester i.
//   - mask[i] clears on the first cycle req_s[i]==0.
// - FSM with states IDLE, GRANT, RELEASE:
//   - IDLE: if elig!=0, pick winner w (see CONFIGURATION), then grant_o<=1<<w, owner_o<=w, tmo_cnt<=0, go to GRANT. Otherwise stay in IDLE.
//   - GRANT: if req_s[owner]==0, then grant_o<=0, owner_o<=2'b11, go to RELEASE.
//   - GRANT: else if tmo_cnt==TIMEOUT_CYCLES-1, then grant_o<=0, timeout_o<=1 for one cycle, mask[owner]<=1, go to RELEASE.
//   - GRANT: else tmo_cnt<=tmo_cnt+1 (saturating; never wraps).
//   - RELEASE: grant_o stays 0 for exactly one cycle, then go to IDLE.
// - Latency:
//   - req_i rising at edge k, seen by an idle arbiter, gives grant_o high at edge k+SYNC_STAGES+1.
//   - req_i falling gives grant_o low SYNC_STAGES+1 edges later.
//   - Handover gap: grant_o==0 for at least 2 cycles (RELEASE + IDLE) between owners.
//   - A grant lasts at most TIMEOUT_CYCLES cycles.
// - Simultaneous events:
//   - Owner releases on the same edge as the timeout: release wins, no timeout_o, no mask.
//   - New requests during GRANT or RELEASE are held (level-sensitive) and arbitrated in IDLE.
//   - A requester that drops and re-raises req in under SYNC_STAGES cycles may never be seen as released. Requesters must hold req low for at least SYNC_STAGES+1 cycles.
// - Invariant: $onehot0(grant_o) on every cycle; grant_o!=0 only in GRANT.
// CONFIGURATION
// - Macro BUS_ARB_ROUND_ROBIN_EN.
// - Defined: round-robin.
//   - The search starts at (rr_last+1) mod 3 and the first eligible index wins.
//   - rr_last<=w on each grant.
//   - After reset, requester 0 has top priority.
// - Undefined: fixed priority, 0 > 1 > 2.
//   - The rr_last register is not instantiated.
//   - Requester 2 can starve if 0 or 1 keep requesting.
// TESTING
// - T1 reset: assert sysrst_n=0 mid-grant -> grant_o=3'b000, owner_o=2'b11, busy_o=0 with no clock edge.
// - T2 single request (SYNC_STAGES=2): req_i=3'b010 at edge 0 -> grant_o=3'b010 at edge 3, owner_o=1. Drop req at edge 10 -> grant_o=0 at edge 13, busy_o=0 at edge 15.
// - T3 contention: req_i=3'b111 held; each owner drops req 4 cycles after its grant.
//   - Fixed priority: grant order 0,0,0...
//   - BUS_ARB_ROUND_ROBIN_EN: grant order 0,1,2,0.
//   - Every handover gap is at least 2 zero cycles.
// - T4 timeout (TIMEOUT_CYCLES=8): req_i=3'b001 held -> grant_o=3'b001 for exactly 8 cycles, then timeout_o pulses once.
//   - Requester 0 is not re-granted while its req stays high.
//   - With req_i=3'b101, requester 2 is granted next.
// - T5 release-at-timeout collision: owner's req_s falls on the final count cycle -> no timeout_o, mask stays 0.
// - T6 random req_i for 10k cycles -> $onehot0(grant_o) always holds; no grant longer than TIMEOUT_CYCLES; owner_o matches grant_o.

Source files
------------

// File: rtl/bus_grant_arbiter_3.sv
// Three-requester bus arbiter: synchronised requests, one-hot grants, timeout revoke.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 0 > 1 > 2.
module bus_grant_arbiter_3 #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TMO_W          = 8
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic [2:0] req_i,
  output logic [2:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [1:0] owner_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  localparam logic [1:0] NO_OWNER = 2'b11;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_ONE =
    TMO_W'(1);

  state_t           state;
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       req_s;
  logic [2:0]       mask;
  logic [2:0]       elig;
  logic [1:0]       win;
  logic             owner_req;
  logic [TMO_W-1:0] tmo_cnt;

  // Request synchroniser chain; only the last stage is used
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= req_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign elig      = req_s & ~mask;
  assign owner_req = |(req_s & grant_o);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_last;
  logic [1:0] rr_start;

  assign rr_start = (rr_last == 2'd2) ?
                    2'd0 : rr_last + 2'd1;

  // Rotating search from the index after the last winner
  always_comb begin
    win = 2'd0;
    unique case (rr_start)
      2'd1: begin
        if (elig[1])      win = 2'd1;
        else if (elig[2]) win = 2'd2;
        else              win = 2'd0;
      end
      2'd2: begin
        if (elig[2])      win = 2'd2;
        else if (elig[0]) win = 2'd0;
        else              win = 2'd1;
      end
      default: begin
        if (elig[0])      win = 2'd0;
        else if (elig[1]) win = 2'd1;
        else              win = 2'd2;
      end
    endcase
  end

  // Remember the last winner; reset value gives requester 0 first turn
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n)
      rr_last <= 2'd2;
    else if (state == IDLE && |elig)
      rr_last <= win;
  end
`else
  // Fixed priority: CPU over DMA over refresh
  always_comb begin
    win = 2'd0;
    if (elig[0])      win = 2'd0;
    else if (elig[1]) win = 2'd1;
    else              win = 2'd2;
  end
`endif

  // Grant sequencer with registered outputs and timeout revoke
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state     <= IDLE;
      grant_o   <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
      owner_o   <= NO_OWNER;
      tmo_cnt   <= '0;
      mask      <= '0;
    end else begin
      timeout_o <= 1'b0;
      busy_o    <= (state != IDLE);
      mask      <= mask & req_s;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            grant_o <= 3'b001 << win;
            owner_o <= win;
            tmo_cnt <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            grant_o <= '0;
            owner_o <= NO_OWNER;
            state   <= RELEASE;
          end else if (tmo_cnt == TMO_LAST) begin
            grant_o   <= '0;
            owner_o   <= NO_OWNER;
            timeout_o <= 1'b1;
            mask      <= (mask & req_s) | grant_o;
            state     <= RELEASE;
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          grant_o <= '0;
          owner_o <= NO_OWNER;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
